// File: rtl/cache_pkg.sv
// Shared widths, address slicing helpers and state encoding for the cache controller.
// Optional statistics counters are enabled with CACHE_CTRL_STATS_EN (see cache_controller).
package cache_pkg;

  localparam int ADDR_W    = 32;
  localparam int TAG_W     = 26;
  localparam int INDEX_W   = 2;
  localparam int LINE_W    = 128;
  localparam int WORD_W    = 32;
  localparam int WORDS     = 4;
  localparam int WSEL_W    = 2;
  localparam int BSEL_W    = 2;
  localparam int OFFSET_W  = 4;
  localparam int LINES     = 4;
  localparam int STAT_W    = 32;

  localparam int TAG_LSB   = 6;
  localparam int INDEX_LSB = 4;
  localparam int WORD_LSB  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMPARE = 3'd1,
    WB_READ = 3'd2,
    WB_MEM  = 3'd3,
    FILL    = 3'd4,
    UPDATE  = 3'd5
  } ctrl_state_t;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]   tag,
                                                   input logic [INDEX_W-1:0] idx);
    return {tag, idx, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_controller_if.sv
// CPU, cache-array and line-memory signals of the cache controller.
// Handshakes: cpu_req is held stable until cpu_ready pulses; mem_req is held until mem_ready pulses.
interface cache_controller_if;
  import cache_pkg::*;

  logic                cpu_req;
  logic                cpu_we;
  logic                cpu_byte;
  logic [ADDR_W-1:0]   cpu_addr;
  logic [WORD_W-1:0]   cpu_wdata;
  logic                cpu_ready;
  logic [WORD_W-1:0]   cpu_rdata;

  logic                c_comp;
  logic                c_write_word;
  logic                c_write_block;
  logic                c_byte_access;
  logic [INDEX_W-1:0]  c_index;
  logic [WSEL_W-1:0]   c_word;
  logic [BSEL_W-1:0]   c_byte;
  logic [TAG_W-1:0]    c_tag;
  logic [WORD_W-1:0]   c_word_in;
  logic [LINE_W-1:0]   c_block_in;
  logic                c_hit;
  logic                c_dirty;
  logic                c_valid;
  logic [WORD_W-1:0]   c_data_out;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W-1:0]   mem_rdata;
  logic                mem_ready;

  modport master (
    input  cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    output cpu_ready, cpu_rdata,
    output c_comp, c_write_word, c_write_block, c_byte_access,
    output c_index, c_word, c_byte, c_tag, c_word_in, c_block_in,
    input  c_hit, c_dirty, c_valid, c_data_out,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    output cpu_req, cpu_we, cpu_byte, cpu_addr, cpu_wdata,
    input  cpu_ready, cpu_rdata,
    input  c_comp, c_write_word, c_write_block, c_byte_access,
    input  c_index, c_word, c_byte, c_tag, c_word_in, c_block_in,
    output c_hit, c_dirty, c_valid, c_data_out,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/cache_line_buffer.sv
// 128-bit line staging register: per-word lane writes for write-back gathering,
// whole-line load for fills. A full-line load takes priority over lane writes.
module cache_line_buffer
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [WORDS-1:0]  lane_we_i,
  input  logic [WORD_W-1:0] lane_data_i,
  input  logic              load_i,
  input  logic [LINE_W-1:0] line_i,
  output logic [LINE_W-1:0] line_o
);

  logic [LINE_W-1:0] line_q, line_d;

  always_comb begin
    line_d = line_q;
    if (load_i) begin
      line_d = line_i;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (lane_we_i[i]) line_d[i*WORD_W +: WORD_W] = lane_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) line_q <= '0;
    else       line_q <= line_d;
  end

  assign line_o = line_q;

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped cache sequencer: tag compare, dirty write-back, line fill, retry.
// Define CACHE_CTRL_STATS_EN to add stat_hits / stat_misses / stat_writebacks counters.
module cache_controller
  import cache_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  cache_controller_if.master   bus,
  output ctrl_state_t          state_o
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]    stat_hits,
  output logic [STAT_W-1:0]    stat_misses,
  output logic [STAT_W-1:0]    stat_writebacks
`endif
);

  ctrl_state_t         state_q, state_d;
  logic                we_q, we_d;
  logic                byte_q, byte_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WSEL_W-1:0]   wb_cnt_q, wb_cnt_d;
  logic [TAG_W-1:0]    shadow_tag_q [LINES];
  logic [TAG_W-1:0]    shadow_tag_d [LINES];

  logic [WORDS-1:0]    lane_we;
  logic                buf_load;
  logic [LINE_W-1:0]   buf_line;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [WSEL_W-1:0]   req_word;
  logic [BSEL_W-1:0]   req_bsel;

  assign req_tag   = addr_q[ADDR_W-1:TAG_LSB];
  assign req_index = addr_q[TAG_LSB-1:INDEX_LSB];
  assign req_word  = addr_q[INDEX_LSB-1:WORD_LSB];
  assign req_bsel  = addr_q[WORD_LSB-1:0];

  cache_line_buffer u_line_buf (
    .clk_i       (clock),
    .rst_i       (reset),
    .lane_we_i   (lane_we),
    .lane_data_i (bus.c_data_out),
    .load_i      (buf_load),
    .line_i      (bus.mem_rdata),
    .line_o      (buf_line)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    byte_d       = byte_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wb_cnt_d     = wb_cnt_q;
    shadow_tag_d = shadow_tag_q;
    lane_we      = '0;
    buf_load     = 1'b0;

    bus.cpu_ready     = 1'b0;
    bus.cpu_rdata     = '0;
    bus.c_comp        = 1'b0;
    bus.c_write_word  = 1'b0;
    bus.c_write_block = 1'b0;
    bus.c_byte_access = 1'b0;
    bus.c_index       = '0;
    bus.c_word        = '0;
    bus.c_byte        = '0;
    bus.c_tag         = '0;
    bus.c_word_in     = '0;
    bus.c_block_in    = '0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;

    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          byte_d  = bus.cpu_byte;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        bus.c_comp        = 1'b1;
        bus.c_index       = req_index;
        bus.c_word        = req_word;
        bus.c_byte        = req_bsel;
        bus.c_tag         = req_tag;
        bus.c_byte_access = byte_q;
        bus.c_word_in     = wdata_q;
        if (bus.c_hit) begin
          bus.cpu_ready = 1'b1;
          if (we_q) bus.c_write_word = 1'b1;
          else      bus.cpu_rdata    = bus.c_data_out;
          state_d = IDLE;
        end else if (bus.c_valid && bus.c_dirty) begin
          wb_cnt_d = '0;
          state_d  = WB_READ;
        end else begin
          state_d = FILL;
        end
      end
      WB_READ: begin
        // Victim is read one word per cycle; each word lands in its own buffer lane.
        bus.c_index       = req_index;
        bus.c_word        = wb_cnt_q;
        lane_we[wb_cnt_q] = 1'b1;
        wb_cnt_d          = wb_cnt_q + 1'b1;
        if (wb_cnt_q == WSEL_W'(WORDS - 1)) state_d = WB_MEM;
      end
      WB_MEM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = line_addr(shadow_tag_q[req_index], req_index);
        bus.mem_wdata = buf_line;
        if (bus.mem_ready) state_d = FILL;
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = line_addr(req_tag, req_index);
        if (bus.mem_ready) begin
          buf_load = 1'b1;
          state_d  = UPDATE;
        end
      end
      UPDATE: begin
        bus.c_write_block       = 1'b1;
        bus.c_block_in          = buf_line;
        bus.c_tag               = req_tag;
        bus.c_index             = req_index;
        shadow_tag_d[req_index] = req_tag;
        state_d                 = COMPARE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wb_cnt_q <= '0;
      for (int i = 0; i < LINES; i++) shadow_tag_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wb_cnt_q <= wb_cnt_d;
      for (int i = 0; i < LINES; i++) shadow_tag_q[i] <= shadow_tag_d[i];
    end
  end

  assign state_o = state_q;

`ifdef CACHE_CTRL_STATS_EN
  // retry_q marks the compare that follows UPDATE so it is not counted a second time.
  logic              retry_q, retry_d;
  logic [STAT_W-1:0] hits_q, hits_d, misses_q, misses_d, wbs_q, wbs_d;

  always_comb begin
    retry_d  = retry_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    wbs_d    = wbs_q;
    if (state_q == UPDATE)    retry_d = 1'b1;
    else if (state_q == IDLE) retry_d = 1'b0;
    if (state_q == COMPARE && !retry_q) begin
      if (bus.c_hit) hits_d   = hits_q + 1'b1;
      else           misses_d = misses_q + 1'b1;
    end
    if (state_q == WB_MEM && bus.mem_ready) wbs_d = wbs_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      retry_q  <= 1'b0;
      hits_q   <= '0;
      misses_q <= '0;
      wbs_q    <= '0;
    end else begin
      retry_q  <= retry_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      wbs_q    <= wbs_d;
    end
  end

  assign stat_hits       = hits_q;
  assign stat_misses     = misses_q;
  assign stat_writebacks = wbs_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller; the bench plays CPU, cache array and line memory.
module tb_cache_controller;
  import cache_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  ctrl_state_t state;
  int          n_cmp = 0;
  int          n_err = 0;
  int          ready_cnt;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writebacks;
`endif

  logic [31:0]  wb_words [4] = '{32'hAAAA_0000, 32'hDEAD_BEEF, 32'h2222_0000, 32'h3333_0000};
  logic [127:0] exp_line;

  cache_controller_if bus();

  cache_controller dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bus),
    .state_o         (state)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .stat_hits       (stat_hits),
    .stat_misses     (stat_misses),
    .stat_writebacks (stat_writebacks)
`endif
  );

  always #5 clock = ~clock;

  // Each window starts 1 time unit after a rising edge, away from both edges.
  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_byte   = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.c_hit      = 1'b0;
    bus.c_dirty    = 1'b0;
    bus.c_valid    = 1'b0;
    bus.c_data_out = '0;
    bus.mem_rdata  = '0;
    bus.mem_ready  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    next();
    next();
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", state, IDLE); end
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_err++; $display("FAIL reset_cpu_ready: got %b want 0", bus.cpu_ready); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
    n_cmp++; if ({bus.c_comp, bus.c_write_word, bus.c_write_block} !== 3'b000) begin n_err++; $display("FAIL reset_cache_ctl: got %b want 000", {bus.c_comp, bus.c_write_word, bus.c_write_block}); end
    n_cmp++; if (bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
`ifdef CACHE_CTRL_STATS_EN
    n_cmp++; if ({stat_hits, stat_misses, stat_writebacks} !== 96'h0) begin n_err++; $display("FAIL reset_stats: got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses, stat_writebacks); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_cold_load();
    next();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0040;
    #1;
    n_cmp++; if (bus.cpu_ready !== 1'b0) begin n_err++; $display("FAIL cold_accept_ready: got %b want 0", bus.cpu_ready); end
    next();
    bus.c_hit = 1'b0; bus.c_valid = 1'b0; bus.c_dirty = 1'b0;
    #1;
    n_cmp++; if (bus.c_comp !== 1'b1) begin n_err++; $display("FAIL cold_comp: got %b want 1", bus.c_comp); end
    n_cmp++; if (bus.c_tag !== 26'd1 || bus.c_index !== 2'd0) begin n_err++; $display("FAIL cold_tag_index: got %h/%h want 1/0", bus.c_tag, bus.c_index); end
    next();
    #1;
    n_cmp++; if (state !== FILL) begin n_err++; $display("FAIL cold_no_wb: got %0d want %0d", state, FILL); end
    n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL cold_fill_req: got req %b we %b addr %h want 1 0 40", bus.mem_req, bus.mem_we, bus.mem_addr); end
    next();
    bus.mem_ready = 1'b1; bus.mem_rdata = {4{32'h1111_0000}};
    next();
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #1;
    n_cmp++; if (state !== UPDATE || bus.c_write_block !== 1'b1) begin n_err++; $display("FAIL cold_update: got state %0d wb %b want %0d 1", state, bus.c_write_block, UPDATE); end
    n_cmp++; if (bus.c_block_in !== {4{32'h1111_0000}}) begin n_err++; $display("FAIL cold_block_in: got %h want %h", bus.c_block_in, {4{32'h1111_0000}}); end
    n_cmp++; if (bus.mem_req !== 1'b0) begin n_err++; $display("FAIL cold_mem_req_drop: got %b want 0", bus.mem_req); end
    next();
    bus.c_hit = 1'b1; bus.c_valid = 1'b1; bus.c_data_out = 32'h1111_0000;
    #1;
    n_cmp++; if (bus.cpu_ready !== 1'b1 || bus.cpu_rdata !== 32'h1111_0000) begin n_err++; $display("FAIL cold_retry_hit: got ready %b data %h want 1 11110000", bus.cpu_ready, bus.cpu_rdata); end
    next();
    drive_idle();
    #1;
    n_cmp++; if (state !== IDLE) begin n_err++; $display("FAIL cold_done_idle: got %0d want %0d", state, IDLE); end
  endtask

  task automatic test_store_hit();
    next();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h0000_0044; bus.cpu_wdata = 32'hDEAD_BEEF;
    next();
    bus.c_hit = 1'b1; bus.c_valid = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_ready !== 1'b1) begin n_err++; $display("FAIL store_ready: got %b want 1", bus.cpu_ready); end
    n_cmp++; if (bus.c_write_word !== 1'b1 || bus.c_word !== 2'd1) begin n_err++; $display("FAIL store_write_word: got we %b word %0d want 1 1", bus.c_write_word, bus.c_word); end
    n_cmp++; if (bus.c_word_in !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_word_in: got %h want deadbeef", bus.c_word_in); end
    next();
    drive_idle();
    #1;
    n_cmp++; if (bus.cpu_ready !== 1'b0 || bus.c_write_word !== 1'b0) begin n_err++; $display("FAIL store_single_pulse: got %b%b want 00", bus.cpu_ready, bus.c_write_word); end
  endtask

  task automatic test_writeback_ignore_req();
    ready_cnt = 0;
    next();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0140;
    next();
    bus.c_hit = 1'b0; bus.c_valid = 1'b1; bus.c_dirty = 1'b1;
    #1;
    n_cmp++; if (bus.c_tag !== 26'd5 || bus.c_index !== 2'd0) begin n_err++; $display("FAIL wb_tag_index: got %h/%h want 5/0", bus.c_tag, bus.c_index); end
    for (int i = 0; i < 4; i++) begin
      next();
      bus.c_valid = 1'b0; bus.c_dirty = 1'b0; bus.c_data_out = wb_words[i];
      #1;
      n_cmp++; if (state !== WB_READ || bus.c_word !== 2'(i)) begin n_err++; $display("FAIL wb_read_%0d: got state %0d word %0d want %0d %0d", i, state, bus.c_word, WB_READ, i); end
    end
    next();
    bus.c_data_out = '0; bus.cpu_req = 1'b0;
    #1;
    exp_line = {wb_words[3], wb_words[2], wb_words[1], wb_words[0]};
    n_cmp++; if (state !== WB_MEM || bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin n_err++; $display("FAIL wb_mem_req: got state %0d req %b we %b want %0d 1 1", state, bus.mem_req, bus.mem_we, WB_MEM); end
    n_cmp++; if (bus.mem_addr !== 32'h40) begin n_err++; $display("FAIL wb_mem_addr: got %h want 40", bus.mem_addr); end
    n_cmp++; if (bus.mem_wdata[63:32] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wb_lane1: got %h want deadbeef", bus.mem_wdata[63:32]); end
    n_cmp++; if (bus.mem_wdata !== exp_line) begin n_err++; $display("FAIL wb_line: got %h want %h", bus.mem_wdata, exp_line); end
    next();
    bus.cpu_req = 1'b1;
    #1;
    n_cmp++; if (state !== WB_MEM) begin n_err++; $display("FAIL wb_req_ignored: got %0d want %0d", state, WB_MEM); end
    next();
    bus.mem_ready = 1'b1;
    next();
    bus.mem_ready = 1'b0;
    #1;
    n_cmp++; if (state !== FILL || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h140) begin n_err++; $display("FAIL wb_then_fill: got state %0d we %b addr %h want %0d 0 140", state, bus.mem_we, bus.mem_addr, FILL); end
    next();
    bus.mem_ready = 1'b1; bus.mem_rdata = {4{32'h5555_0000}};
    next();
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    #1;
    n_cmp++; if (state !== UPDATE || bus.c_tag !== 26'd5) begin n_err++; $display("FAIL wb_update: got state %0d tag %h want %0d 5", state, bus.c_tag, UPDATE); end
    next();
    bus.c_hit = 1'b1; bus.c_data_out = 32'h5555_0000;
    #1;
    if (bus.cpu_ready === 1'b1) ready_cnt++;
    n_cmp++; if (bus.cpu_rdata !== 32'h5555_0000) begin n_err++; $display("FAIL wb_retry_data: got %h want 55550000", bus.cpu_rdata); end
    next();
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.cpu_ready === 1'b1) ready_cnt++;
      next();
    end
    n_cmp++; if (ready_cnt !== 1) begin n_err++; $display("FAIL wb_once: got %0d completions want 1", ready_cnt); end
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats();
    n_cmp++; if (stat_hits !== 32'd1) begin n_err++; $display("FAIL stat_hits: got %0d want 1", stat_hits); end
    n_cmp++; if (stat_misses !== 32'd2) begin n_err++; $display("FAIL stat_misses: got %0d want 2", stat_misses); end
    n_cmp++; if (stat_writebacks !== 32'd1) begin n_err++; $display("FAIL stat_writebacks: got %0d want 1", stat_writebacks); end
  endtask
`endif

  task automatic test_reset_mid_fill();
    next();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0080;
    next();
    bus.c_hit = 1'b0; bus.c_valid = 1'b0; bus.c_dirty = 1'b0;
    next();
    #1;
    n_cmp++; if (state !== FILL) begin n_err++; $display("FAIL rst_fill_reached: got %0d want %0d", state, FILL); end
    reset = 1'b1; bus.cpu_req = 1'b0;
    next();
    #1;
    n_cmp++; if (state !== IDLE || bus.mem_req !== 1'b0 || bus.cpu_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_fill: got state %0d req %b ready %b want %0d 0 0", state, bus.mem_req, bus.cpu_ready, IDLE); end
`ifdef CACHE_CTRL_STATS_EN
    n_cmp++; if ({stat_hits, stat_misses, stat_writebacks} !== 96'h0) begin n_err++; $display("FAIL rst_stats: got %0d/%0d/%0d want 0/0/0", stat_hits, stat_misses, stat_writebacks); end
`endif
    reset = 1'b0;
  endtask

  // After reset the shadow tag of line 0 is 0, so a dirty victim writes back to 0x0.
  task automatic test_shadow_cleared();
    next();
    bus.cpu_req = 1'b1; bus.cpu_addr = 32'h0000_0080;
    next();
    bus.c_hit = 1'b0; bus.c_valid = 1'b1; bus.c_dirty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      next();
      bus.c_valid = 1'b0; bus.c_dirty = 1'b0;
    end
    next();
    #1;
    n_cmp++; if (state !== WB_MEM || bus.mem_addr !== 32'h0) begin n_err++; $display("FAIL shadow_reset_addr: got state %0d addr %h want %0d 0", state, bus.mem_addr, WB_MEM); end
    reset = 1'b1; bus.cpu_req = 1'b0;
    next();
    #1;
    n_cmp++; if (bus.mem_req !== 1'b0 || state !== IDLE) begin n_err++; $display("FAIL rst_mid_wb: got req %b state %0d want 0 %0d", bus.mem_req, state, IDLE); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_writeback_ignore_req();
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    test_reset_mid_fill();
    test_shadow_cleared();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
